// File: rtl/snac_db15_poller.sv
// SNAC DB15 controller poller: periodically latches the two-player shift chain,
// clocks out 2*BITS active-low bits and publishes decoded button words.
module snac_db15_poller #(
   parameter int CLK_DIV    = 32,
   parameter int POLL_TICKS = 2320,
   parameter int BITS       = 12
) (
   input  logic        clk_74a,
   input  logic        reset_l_main,
   input  logic        enable,
   input  logic        joy_data,
   output logic        joy_clk,
   output logic        joy_load,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        p1_present,
   output logic        p2_present,
   output logic        frame_valid,
   output logic        busy
);

   localparam int NBITS = 2 * BITS;
   localparam int TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PW    = $clog2(POLL_TICKS + 1);
   localparam int IW    = $clog2(NBITS + 1);

   typedef enum logic [2:0] {IDLE, LATCH, SETTLE, HIGH, DONE} state_t;

   state_t             state_q, state_d;
   logic [TW-1:0]      tick_cnt;
   logic               tick;
   logic [PW-1:0]      poll_q, poll_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [NBITS-1:0]   raw_q, raw_d;
   logic               latch_second_q, latch_second_d;
   logic [1:0]         sync_q;
   logic               sample;
   logic               publish;
   logic [15:0]        js1_d, js2_d;
   logic               p1_any, p2_any;

   assign tick   = (tick_cnt == TW'(CLK_DIV - 1));
   assign sample = sync_q[1];

   always_ff @(posedge clk_74a or negedge reset_l_main) begin
      if (!reset_l_main) begin
         tick_cnt <= '0;
         sync_q   <= 2'b11;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         sync_q   <= {sync_q[0], joy_data};
      end
   end

   // The idle timer saturates so a late enable starts a frame on the very next tick.
   always_comb begin
      state_d        = state_q;
      poll_d         = poll_q;
      idx_d          = idx_q;
      raw_d          = raw_q;
      latch_second_d = latch_second_q;
      case (state_q)
         IDLE: begin
            if (tick) begin
               if (enable && (poll_q >= PW'(POLL_TICKS - 1))) begin
                  state_d        = LATCH;
                  poll_d         = '0;
                  latch_second_d = 1'b0;
               end else if (poll_q < PW'(POLL_TICKS)) begin
                  poll_d = poll_q + PW'(1);
               end
            end
         end
         LATCH: begin
            if (tick) begin
               if (latch_second_q) begin
                  state_d = SETTLE;
                  idx_d   = '0;
               end else begin
                  latch_second_d = 1'b1;
               end
            end
         end
         SETTLE: begin
            if (tick) begin
               raw_d[idx_q] = sample;
               idx_d        = idx_q + IW'(1);
               state_d      = (idx_q == IW'(NBITS - 1)) ? DONE : HIGH;
            end
         end
         HIGH: begin
            if (tick) state_d = SETTLE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Published words come from raw_d so the final bit lands in the same cycle as frame_valid.
   always_comb begin
      publish = (state_q == SETTLE) && (state_d == DONE);
      p1_any  = |raw_d[BITS-1:0];
      p2_any  = |raw_d[NBITS-1:BITS];
      js1_d   = '0;
      js2_d   = '0;
      if (p1_any) js1_d[BITS-1:0] = ~raw_d[BITS-1:0];
      if (p2_any) js2_d[BITS-1:0] = ~raw_d[NBITS-1:BITS];
   end

   always_ff @(posedge clk_74a or negedge reset_l_main) begin
      if (!reset_l_main) begin
         state_q        <= IDLE;
         poll_q         <= '0;
         idx_q          <= '0;
         raw_q          <= '0;
         latch_second_q <= 1'b0;
         joy_clk        <= 1'b0;
         joy_load       <= 1'b0;
         frame_valid    <= 1'b0;
         busy           <= 1'b0;
         joystick1      <= '0;
         joystick2      <= '0;
         p1_present     <= 1'b0;
         p2_present     <= 1'b0;
      end else begin
         state_q        <= state_d;
         poll_q         <= poll_d;
         idx_q          <= idx_d;
         raw_q          <= raw_d;
         latch_second_q <= latch_second_d;
         joy_clk        <= (state_d == HIGH);
         joy_load       <= (state_d == LATCH);
         frame_valid    <= (state_d == DONE);
         busy           <= (state_d != IDLE);
         if (publish) begin
            joystick1  <= js1_d;
            joystick2  <= js2_d;
            p1_present <= p1_any;
            p2_present <= p2_any;
         end
      end
   end

endmodule

// File: tb/tb_snac_db15_poller.sv
// Self-checking bench for snac_db15_poller: a behavioural shift-chain pad model feeds
// table-driven and random button patterns; frame timing and reset/enable corners are checked.
module tb_snac_db15_poller;

   localparam int CLK_DIV    = 2;
   localparam int POLL_TICKS = 4;
   localparam int BITS       = 12;

   logic        clk_74a = 1'b0;
   logic        reset_l_main;
   logic        enable;
   logic        joy_data;
   logic        joy_clk;
   logic        joy_load;
   logic [15:0] joystick1;
   logic [15:0] joystick2;
   logic        p1_present;
   logic        p2_present;
   logic        frame_valid;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   snac_db15_poller #(
      .CLK_DIV   (CLK_DIV),
      .POLL_TICKS(POLL_TICKS),
      .BITS      (BITS)
   ) dut (
      .clk_74a     (clk_74a),
      .reset_l_main(reset_l_main),
      .enable      (enable),
      .joy_data    (joy_data),
      .joy_clk     (joy_clk),
      .joy_load    (joy_load),
      .joystick1   (joystick1),
      .joystick2   (joystick2),
      .p1_present  (p1_present),
      .p2_present  (p2_present),
      .frame_valid (frame_valid),
      .busy        (busy)
   );

   always #5 clk_74a = ~clk_74a;

   // Pad model: parallel load of active-low buttons, shift one bit per joy_clk rising edge.
   logic [11:0] press1 = '0;
   logic [11:0] press2 = '0;
   int          data_mode = 1;
   logic [23:0] chain_sh = '1;
   logic        chain_jc_prev = 1'b0;

   always @(posedge clk_74a) begin
      if (joy_load) chain_sh <= ~{press2, press1};
      else if (joy_clk && !chain_jc_prev) chain_sh <= {1'b1, chain_sh[23:1]};
      chain_jc_prev <= joy_clk;
   end

   assign joy_data = (data_mode == 0) ? chain_sh[0] : (data_mode == 1);

   int   cyc = 0;
   int   fv_total = 0, jc_rise_total = 0, jl_cyc_total = 0, jl_rise_total = 0, busy_total = 0;
   logic mon_jc = 1'b0, mon_jl = 1'b0;

   always @(posedge clk_74a) cyc <= cyc + 1;

   always @(negedge clk_74a) begin
      if (frame_valid) fv_total <= fv_total + 1;
      if (joy_clk && !mon_jc) jc_rise_total <= jc_rise_total + 1;
      if (joy_load) jl_cyc_total <= jl_cyc_total + 1;
      if (joy_load && !mon_jl) jl_rise_total <= jl_rise_total + 1;
      if (busy) busy_total <= busy_total + 1;
      mon_jc <= joy_clk;
      mon_jl <= joy_load;
   end

   typedef struct {
      int          mode;
      logic [11:0] p1;
      logic [11:0] p2;
      logic [15:0] exp_j1;
      logic [15:0] exp_j2;
      logic        exp_p1;
      logic        exp_p2;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(negedge clk_74a);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input int mode, input logic [11:0] p1, input logic [11:0] p2);
      data_mode = mode;
      press1    = p1;
      press2    = p2;
   endtask

   task automatic wait_fv(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (frame_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_output("frame_valid_timeout", 0, 1);
   endtask

   task automatic edges_to_load(input int budget, output int n);
      n = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_74a);
         n++;
         @(negedge clk_74a);
         #1;
         if (joy_load) break;
      end
   endtask

   // Reference: a pad whose lines all read low is unplugged; otherwise buttons are the pressed set.
   function automatic void ref_pad(input int mode, input logic [11:0] pressed,
                                   output logic [15:0] js, output logic present);
      logic [11:0] levels;
      if (mode == 0)      levels = ~pressed;
      else if (mode == 1) levels = 12'hFFF;
      else                levels = 12'h000;
      present = (levels != 12'h000);
      js      = present ? {4'h0, ~levels} : 16'h0000;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_joy_clk"},     joy_clk,     0);
      check_output({tag, "_joy_load"},    joy_load,    0);
      check_output({tag, "_frame_valid"}, frame_valid, 0);
      check_output({tag, "_busy"},        busy,        0);
      check_output({tag, "_joystick1"},   joystick1,   0);
      check_output({tag, "_joystick2"},   joystick2,   0);
      check_output({tag, "_p1_present"},  p1_present,  0);
      check_output({tag, "_p2_present"},  p2_present,  0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit          ok;
      int          n, t0, s_fv, s_jc, s_jl, s_jlr, s_busy;
      logic [15:0] e1, e2;
      logic        ep1, ep2;
      logic [11:0] r1, r2;

      vecs[0] = '{0, 12'h001, 12'h800, 16'h0001, 16'h0800, 1'b1, 1'b1};
      vecs[1] = '{2, 12'h000, 12'h000, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[2] = '{1, 12'h000, 12'h000, 16'h0000, 16'h0000, 1'b1, 1'b1};
      vecs[3] = '{0, 12'hFFF, 12'h0A5, 16'h0000, 16'h00A5, 1'b0, 1'b1};
      vecs[4] = '{0, 12'h5A3, 12'hFFF, 16'h05A3, 16'h0000, 1'b1, 1'b0};
      vecs[5] = '{0, 12'h800, 12'h001, 16'h0800, 16'h0001, 1'b1, 1'b1};

      reset_l_main = 1'b0;
      enable       = 1'b1;
      apply_stimulus(1, 12'h000, 12'h000);
      repeat (3) step();
      check_reset_outputs("reset");

      // First frame with joy_data idle-high; snapshot counters while idle.
      s_fv = fv_total; s_jc = jc_rise_total; s_jl = jl_cyc_total; s_busy = busy_total;
      reset_l_main = 1'b1;
      edges_to_load(100, n);
      check_output("first_latch_edges", n, CLK_DIV * POLL_TICKS);
      wait_fv(300, ok);
      check_output("frame_fv_count",   fv_total - s_fv, 1);
      check_output("frame_clk_rises",  jc_rise_total - s_jc, 2 * BITS - 1);
      check_output("frame_load_cycles", jl_cyc_total - s_jl, 2 * CLK_DIV);
      check_output("frame_busy_cycles", busy_total - s_busy, CLK_DIV * (3 + 2 * (2 * BITS - 1)) + 1);
      check_output("high_j1", joystick1, 16'h0000);
      check_output("high_j2", joystick2, 16'h0000);
      check_output("high_p1", p1_present, 1);
      check_output("high_p2", p2_present, 1);
      t0 = cyc;
      step();
      check_output("fv_one_cycle", frame_valid, 0);
      wait_fv(300, ok);
      check_output("frame_period_cycles", cyc - t0,
                   CLK_DIV * (3 + 2 * (2 * BITS - 1) + POLL_TICKS));

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].mode, vecs[i].p1, vecs[i].p2);
         wait_fv(300, ok);
         wait_fv(300, ok);
         check_output($sformatf("vec%0d_j1", i), joystick1,  vecs[i].exp_j1);
         check_output($sformatf("vec%0d_j2", i), joystick2,  vecs[i].exp_j2);
         check_output($sformatf("vec%0d_p1", i), p1_present, vecs[i].exp_p1);
         check_output($sformatf("vec%0d_p2", i), p2_present, vecs[i].exp_p2);
         apply_stimulus(0, 12'h3C3, 12'h0F0);
         repeat (20) step();
         check_output($sformatf("vec%0d_hold_j1", i), joystick1, vecs[i].exp_j1);
      end

      for (int k = 0; k < 10; k++) begin
         r1 = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
         r2 = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
         apply_stimulus(0, r1, r2);
         wait_fv(300, ok);
         wait_fv(300, ok);
         ref_pad(0, r1, e1, ep1);
         ref_pad(0, r2, e2, ep2);
         check_output($sformatf("rnd%0d_j1", k), joystick1,  e1);
         check_output($sformatf("rnd%0d_j2", k), joystick2,  e2);
         check_output($sformatf("rnd%0d_p1", k), p1_present, ep1);
         check_output($sformatf("rnd%0d_p2", k), p2_present, ep2);
      end

      // Drop enable ten ticks into a frame: it must still finish and publish.
      apply_stimulus(0, 12'h003, 12'h100);
      wait_fv(300, ok);
      for (int i = 0; i < 300; i++) begin
         step();
         if (joy_load) break;
      end
      repeat (10 * CLK_DIV) step();
      enable = 1'b0;
      s_fv = fv_total;
      wait_fv(300, ok);
      check_output("endrop_fv_count", fv_total - s_fv, 1);
      check_output("endrop_j1", joystick1, 16'h0003);
      check_output("endrop_j2", joystick2, 16'h0100);
      s_fv = fv_total; s_jlr = jl_rise_total;
      repeat (300) step();
      check_output("endrop_no_latch", jl_rise_total - s_jlr, 0);
      check_output("endrop_no_fv", fv_total - s_fv, 0);
      check_output("endrop_idle_busy", busy, 0);
      enable = 1'b1;
      edges_to_load(100, n);
      check_output("enable_relatch_next_tick", (n >= 1 && n <= CLK_DIV), 1);

      // Reset pulse while joy_clk is high aborts the frame immediately.
      for (int i = 0; i < 300; i++) begin
         step();
         if (joy_clk) break;
      end
      check_output("reached_high", joy_clk, 1);
      s_fv = fv_total;
      reset_l_main = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) step();
      reset_l_main = 1'b1;
      edges_to_load(100, n);
      check_output("post_reset_latch_edges", n, CLK_DIV * POLL_TICKS);
      check_output("post_reset_no_fv", fv_total - s_fv, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
